// File: rtl/branch_resolve_unit.sv
// Execute-stage branch resolution: carries prediction and PC+4 through D/E, resolves the real outcome,
// drives predictor correction and flush request, and keeps saturating branch/mispredict counters.
module branch_resolve_unit #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             PredictF,
    input  logic [XLEN-1:0]  PCPlus4F,
    input  logic             StallD,
    input  logic             FlushD,
    input  logic             FlushE,
    input  logic             BranchE,
    input  logic             JumpE,
    input  logic             JalrE,
    input  logic             CondTakenE,
    input  logic [XLEN-1:0]  PCTargetE,
    output logic             Eval_branch,
    output logic             jalr,
    output logic [XLEN-1:0]  Act_Target,
    output logic             PCSrcE,
    output logic             StateUpdateEnable,
    output logic             FlushReq,
    output logic [CNT_W-1:0] BranchCount,
    output logic [CNT_W-1:0] MispredCount
);

    typedef enum logic {RUN = 1'b0, SHADOW = 1'b1} state_t;

    state_t            state_q, state_d;
    logic              valid_dst_q, valid_dst_d;
    logic              pred_dst_q, pred_dst_d;
    logic [XLEN-1:0]   pc4_dst_q, pc4_dst_d;
    logic              valid_est_q, valid_est_d;
    logic              pred_est_q, pred_est_d;
    logic [XLEN-1:0]   pc4_est_q, pc4_est_d;
    logic [CNT_W-1:0]  br_cnt_q, br_cnt_d;
    logic [CNT_W-1:0]  mis_cnt_q, mis_cnt_d;

    logic taken;
    logic live;
    logic eval_int;
    logic jalr_int;
    logic is_bj;

    // Everything is gated by live so the wrong-path slot after a redirect is fully inert.
    assign taken    = (BranchE & CondTakenE) | JumpE;
    assign live     = valid_est_q & (state_q == RUN);
    assign is_bj    = BranchE | JumpE;
    assign eval_int = live & is_bj & (pred_est_q != taken);
    assign jalr_int = live & JalrE;

    assign Eval_branch       = eval_int;
    assign jalr              = jalr_int;
    assign FlushReq          = eval_int | jalr_int;
    assign PCSrcE            = live & taken;
    assign StateUpdateEnable = live & BranchE;
    assign Act_Target        = !live ? '0 : ((jalr_int | taken) ? PCTargetE : pc4_est_q);
    assign BranchCount       = br_cnt_q;
    assign MispredCount      = mis_cnt_q;

    always_comb begin
        valid_dst_d = valid_dst_q;
        pred_dst_d  = pred_dst_q;
        pc4_dst_d   = pc4_dst_q;
        if (FlushD) begin
            valid_dst_d = 1'b0;
            pred_dst_d  = 1'b0;
        end else if (!StallD) begin
            valid_dst_d = 1'b1;
            pred_dst_d  = PredictF;
            pc4_dst_d   = PCPlus4F;
        end

        valid_est_d = valid_dst_q & ~FlushE;
        pred_est_d  = pred_dst_q & ~FlushE;
        pc4_est_d   = pc4_dst_q;

        state_d = state_q;
        case (state_q)
            RUN:     if (eval_int | jalr_int) state_d = SHADOW;
            SHADOW:  state_d = RUN;
            default: state_d = RUN;
        endcase

        br_cnt_d  = br_cnt_q;
        mis_cnt_d = mis_cnt_q;
        if (live && is_bj && (br_cnt_q != {CNT_W{1'b1}}))
            br_cnt_d = br_cnt_q + CNT_W'(1);
        if (eval_int && (mis_cnt_q != {CNT_W{1'b1}}))
            mis_cnt_d = mis_cnt_q + CNT_W'(1);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= RUN;
            valid_dst_q <= 1'b0;
            pred_dst_q  <= 1'b0;
            pc4_dst_q   <= '0;
            valid_est_q <= 1'b0;
            pred_est_q  <= 1'b0;
            pc4_est_q   <= '0;
            br_cnt_q    <= '0;
            mis_cnt_q   <= '0;
        end else begin
            state_q     <= state_d;
            valid_dst_q <= valid_dst_d;
            pred_dst_q  <= pred_dst_d;
            pc4_dst_q   <= pc4_dst_d;
            valid_est_q <= valid_est_d;
            pred_est_q  <= pred_est_d;
            pc4_est_q   <= pc4_est_d;
            br_cnt_q    <= br_cnt_d;
            mis_cnt_q   <= mis_cnt_d;
        end
    end

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Bench for branch_resolve_unit: directed vector table, hand-written corner sequences and a
// randomized run against a cycle-level reference model of the pipeline slots.
module tb_branch_resolve_unit;

    localparam int XLEN  = 32;
    localparam int CNT_W = 4;
    localparam int CMAX  = 15;

    logic             clk = 1'b0;
    logic             reset;
    logic             PredictF;
    logic [XLEN-1:0]  PCPlus4F;
    logic             StallD, FlushD, FlushE;
    logic             BranchE, JumpE, JalrE, CondTakenE;
    logic [XLEN-1:0]  PCTargetE;
    logic             Eval_branch, jalr, PCSrcE, StateUpdateEnable, FlushReq;
    logic [XLEN-1:0]  Act_Target;
    logic [CNT_W-1:0] BranchCount, MispredCount;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    branch_resolve_unit #(.XLEN(XLEN), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset), .PredictF(PredictF), .PCPlus4F(PCPlus4F),
        .StallD(StallD), .FlushD(FlushD), .FlushE(FlushE),
        .BranchE(BranchE), .JumpE(JumpE), .JalrE(JalrE), .CondTakenE(CondTakenE),
        .PCTargetE(PCTargetE), .Eval_branch(Eval_branch), .jalr(jalr),
        .Act_Target(Act_Target), .PCSrcE(PCSrcE), .StateUpdateEnable(StateUpdateEnable),
        .FlushReq(FlushReq), .BranchCount(BranchCount), .MispredCount(MispredCount)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_ctrl();
        StallD = 0; FlushD = 0; FlushE = 0;
        BranchE = 0; JumpE = 0; JalrE = 0; CondTakenE = 0; PCTargetE = '0;
    endtask

    task automatic chk_outs_zero(input string tag);
        chk({tag, ".eval"}, 32'(Eval_branch), 0);
        chk({tag, ".jalr"}, 32'(jalr), 0);
        chk({tag, ".tgt"},  Act_Target, 0);
        chk({tag, ".pcsrc"}, 32'(PCSrcE), 0);
        chk({tag, ".sue"},  32'(StateUpdateEnable), 0);
        chk({tag, ".flush"}, 32'(FlushReq), 0);
    endtask

    task automatic do_reset();
        idle_ctrl();
        PredictF = 0; PCPlus4F = '0;
        reset = 1;
        #1;
        step();
        reset = 0;
    endtask

    typedef struct {
        logic        pred;
        logic [31:0] pc4;
        logic        br, jmp, jr, cond, fe;
        logic [31:0] tgt;
        logic        x_eval, x_jalr;
        logic [31:0] x_tgt;
        logic        x_pcsrc, x_sue, x_br_inc, x_mis_inc;
    } vec_t;

    vec_t vecs[7];

    // Reference model state: one record per pipeline slot, shadow flag, counters.
    typedef struct { logic valid; logic pred; logic [31:0] pc4; } slot_t;
    slot_t m_d, m_e;
    bit    m_shadow;
    int    m_bc, m_mc;

    initial begin
        int exp_bc, exp_mc, t;
        bit ok;
        reset = 1; idle_ctrl(); PredictF = 0; PCPlus4F = '0;
        //           pred pc4     br jmp jr cond fe tgt        eval jalr x_tgt     pcsrc sue bi mi
        vecs[0] = '{1, 32'h14, 1, 0, 0, 1, 0, 32'h100,   0, 0, 32'h100,   1, 1, 1, 0};
        vecs[1] = '{1, 32'h24, 1, 0, 0, 0, 0, 32'h180,   1, 0, 32'h24,    0, 1, 1, 1};
        vecs[2] = '{0, 32'h30, 0, 1, 0, 0, 0, 32'h200,   1, 0, 32'h200,   1, 0, 1, 1};
        vecs[3] = '{0, 32'h40, 0, 0, 1, 0, 0, 32'h3F0,   0, 1, 32'h3F0,   0, 0, 0, 0};
        vecs[4] = '{0, 32'h44, 1, 0, 0, 1, 0, 32'h80,    1, 0, 32'h80,    1, 1, 1, 1};
        vecs[5] = '{0, 32'h48, 1, 0, 0, 0, 1, 32'h90,    0, 0, 32'h48,    0, 1, 1, 0};
        vecs[6] = '{1, 32'h4C, 0, 1, 0, 0, 1, 32'h220,   0, 0, 32'h220,   1, 0, 1, 0};

        #2;
        chk_outs_zero("reset_during");
        chk("reset.bc", 32'(BranchCount), 0);
        chk("reset.mc", 32'(MispredCount), 0);
        step();
        reset = 0;
        step();
        @(negedge clk);
        chk_outs_zero("reset_after");

        // Directed vector table
        do_reset();
        exp_bc = 0; exp_mc = 0;
        for (int i = 0; i < 7; i++) begin
            idle_ctrl();
            PredictF = vecs[i].pred; PCPlus4F = vecs[i].pc4;
            step(); step();
            BranchE = vecs[i].br; JumpE = vecs[i].jmp; JalrE = vecs[i].jr;
            CondTakenE = vecs[i].cond; FlushE = vecs[i].fe; PCTargetE = vecs[i].tgt;
            @(negedge clk);
            chk($sformatf("v%0d.eval", i), 32'(Eval_branch), 32'(vecs[i].x_eval));
            chk($sformatf("v%0d.jalr", i), 32'(jalr), 32'(vecs[i].x_jalr));
            chk($sformatf("v%0d.tgt", i), Act_Target, vecs[i].x_tgt);
            chk($sformatf("v%0d.pcsrc", i), 32'(PCSrcE), 32'(vecs[i].x_pcsrc));
            chk($sformatf("v%0d.sue", i), 32'(StateUpdateEnable), 32'(vecs[i].x_sue));
            chk($sformatf("v%0d.flush", i), 32'(FlushReq), 32'(vecs[i].x_eval | vecs[i].x_jalr));
            step();
            exp_bc += vecs[i].x_br_inc; exp_mc += vecs[i].x_mis_inc;
            chk($sformatf("v%0d.bc", i), 32'(BranchCount), 32'(exp_bc));
            chk($sformatf("v%0d.mc", i), 32'(MispredCount), 32'(exp_mc));
            // Offer a live-looking JALR next cycle: it must be masked after a flush or a FlushE.
            idle_ctrl(); JalrE = 1; PCTargetE = 32'h777;
            @(negedge clk);
            chk($sformatf("v%0d.next_jalr", i), 32'(jalr),
                32'(!(vecs[i].x_eval | vecs[i].x_jalr) && !vecs[i].fe));
            chk($sformatf("v%0d.next_eval", i), 32'(Eval_branch), 0);
            step(); idle_ctrl(); step(); step();
            $display("vec %0d pc4=0x%0h done", i, vecs[i].pc4);
        end

        // Stalled predicted-taken instr is killed by FlushD+StallD and never trains
        do_reset();
        PredictF = 1; PCPlus4F = 32'h50;
        step();
        StallD = 1; FlushE = 1;
        step(); step(); step();
        FlushD = 1;
        step();
        idle_ctrl(); PredictF = 0;
        step();
        BranchE = 1; CondTakenE = 1; PCTargetE = 32'h60;
        @(negedge clk);
        chk("stall_flush.sue", 32'(StateUpdateEnable), 0);
        chk("stall_flush.eval", 32'(Eval_branch), 0);
        chk("stall_flush.tgt", Act_Target, 0);
        $display("stall+flushD sequence done");

        // Saturation: back-to-back mispredicting JALs
        do_reset();
        PredictF = 0; JumpE = 1; PCTargetE = 32'h500;
        ok = 0;
        for (t = 0; t < 100 && !ok; t++) begin
            @(negedge clk);
            if (MispredCount == 4'd14) ok = 1;
        end
        chk("sat.reach14", 32'(ok), 1);
        chk("sat.bc14", 32'(BranchCount), 14);
        repeat (8) @(negedge clk);
        chk("sat.mc_hold", 32'(MispredCount), CMAX);
        chk("sat.bc_hold", 32'(BranchCount), CMAX);
        $display("saturation sequence done");

        // Reset asserted while a redirect is on the outputs
        ok = 0;
        for (t = 0; t < 10 && !ok; t++) begin
            @(negedge clk);
            if (Eval_branch) ok = 1;
        end
        chk("rst_redir.seen", 32'(ok), 1);
        reset = 1; #1;
        chk("rst_redir.eval", 32'(Eval_branch), 0);
        chk("rst_redir.mc", 32'(MispredCount), 0);
        step(); reset = 0;
        step(); step();
        @(negedge clk);
        chk("rst_redir.run_again", 32'(Eval_branch), 1);

        // Reset asserted mid-SHADOW clears counters without waiting for an edge
        @(posedge clk); #2;
        chk("rst_shadow.masked", 32'(Eval_branch), 0);
        chk("rst_shadow.mc_pre", 32'(MispredCount), 1);
        reset = 1; #1;
        chk("rst_shadow.mc", 32'(MispredCount), 0);
        chk("rst_shadow.bc", 32'(BranchCount), 0);
        chk_outs_zero("rst_shadow");
        step(); reset = 0;
        $display("reset corner sequences done");

        // Randomized run against the reference model
        for (int blk = 0; blk < 5; blk++) begin
            do_reset();
            m_d = '{0, 0, 0}; m_e = '{0, 0, 0}; m_shadow = 0; m_bc = 0; m_mc = 0;
            for (int c = 0; c < 40; c++) begin
                bit   taken, live, e_eval, e_jalr, e_pcsrc, e_sue;
                logic [31:0] e_tgt;
                slot_t nd, ne;
                int   kind;
                PredictF   = 1'($urandom);
                PCPlus4F   = $urandom & 32'hFFFF_FFFC;
                StallD     = ($urandom_range(0, 3) == 0);
                FlushD     = ($urandom_range(0, 5) == 0);
                FlushE     = ($urandom_range(0, 5) == 0);
                kind       = $urandom_range(0, 3);
                BranchE    = (kind == 1);
                JumpE      = (kind == 2);
                JalrE      = (kind == 3);
                CondTakenE = 1'($urandom);
                PCTargetE  = $urandom & 32'hFFFF_FFFE;
                @(negedge clk);
                taken   = (BranchE && CondTakenE) || JumpE;
                live    = m_e.valid && !m_shadow;
                e_eval  = live && (BranchE || JumpE) && (m_e.pred != taken);
                e_jalr  = live && JalrE;
                e_pcsrc = live && taken;
                e_sue   = live && BranchE;
                e_tgt   = !live ? 32'h0 : ((e_jalr || taken) ? PCTargetE : m_e.pc4);
                chk("rnd.eval", 32'(Eval_branch), 32'(e_eval));
                chk("rnd.jalr", 32'(jalr), 32'(e_jalr));
                chk("rnd.tgt", Act_Target, e_tgt);
                chk("rnd.pcsrc", 32'(PCSrcE), 32'(e_pcsrc));
                chk("rnd.sue", 32'(StateUpdateEnable), 32'(e_sue));
                chk("rnd.flush", 32'(FlushReq), 32'(e_eval || e_jalr));
                chk("rnd.bc", 32'(BranchCount), 32'(m_bc));
                chk("rnd.mc", 32'(MispredCount), 32'(m_mc));
                nd = m_d;
                if (FlushD) begin nd.valid = 0; nd.pred = 0; end
                else if (!StallD) nd = '{1, PredictF, PCPlus4F};
                ne = '{m_d.valid && !FlushE, m_d.pred && !FlushE, m_d.pc4};
                step();
                m_shadow = !m_shadow && (e_eval || e_jalr);
                if (live && (BranchE || JumpE) && m_bc < CMAX) m_bc++;
                if (e_eval && m_mc < CMAX) m_mc++;
                m_d = nd; m_e = ne;
            end
            $display("random block %0d done, bc=%0d mc=%0d", blk, m_bc, m_mc);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
